tag_logic_fsm: RTL and testbench

Per-buffer-tag lifecycle controller for double-buffered accelerator memories; this is the `tag_logic` module. One instance exists per tag, inside the tag-synchronisation layer. It walks its tag through four phases: free, load-memory, compute and store-memory. It tracks compute reuse of the loaded data and latches per-tag switch flags for the compute and store engines.

---
 rtl/tag_logic_fsm.sv | 123 ++++++++++++
 tb/tb_tag_logic_fsm.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tag_logic_fsm.sv
// Per-tag buffer lifecycle controller: FREE -> LDMEM -> COMPUTE -> (STMEM) -> FREE.
// Optional compute-reuse counter enabled by defining TAG_LOGIC_REUSE_EN.
module tag_logic_fsm #(
    parameter bit STORE_ENABLED = 1'b1,
    parameter int REUSE_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tag_req,
    input  logic tag_reuse,
    input  logic tag_bias_prev_sw,
    input  logic tag_ddr_pe_sw,
    input  logic tag_flush,
    input  logic tag_done,
    input  logic next_sync_compute_tag,
    input  logic ldmem_tag_done,
    input  logic compute_tag_done,
    input  logic stmem_tag_done,
    output logic tag_ready,
    output logic ldmem_tag_ready,
    output logic compute_tag_ready,
    output logic stmem_tag_ready,
    output logic next_compute_tag,
    output logic compute_bias_prev_sw,
    output logic stmem_ddr_pe_sw
);

    // state   | meaning
    // FREE    | tag idle, waiting for tag_req
    // LDMEM   | load engine filling the buffer
    // COMPUTE | compute engine passes over the buffer
    // STMEM   | store engine draining results
    typedef enum logic [1:0] {
        S_FREE    = 2'd0,
        S_LDMEM   = 2'd1,
        S_COMPUTE = 2'd2,
        S_STMEM   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_flush;
    logic                 r_bias_prev_sw;
    logic                 r_ddr_pe_sw;
    logic [REUSE_W-1:0]   w_reuse_cnt;
    logic                 w_req_accept;
    logic                 w_active;
    logic                 w_exit;

    assign w_req_accept = (r_state == S_FREE) && tag_req;
    assign w_active     = (r_state == S_LDMEM) || (r_state == S_COMPUTE);
    assign w_exit       = (r_state == S_COMPUTE) && compute_tag_done
                          && (r_flush || tag_flush) && (w_reuse_cnt == '0);

`ifdef TAG_LOGIC_REUSE_EN
    logic [REUSE_W-1:0] r_reuse_cnt;
    logic               w_inc;
    logic               w_dec;

    assign w_inc = w_active && tag_reuse;
    assign w_dec = (r_state == S_COMPUTE) && compute_tag_done && (r_reuse_cnt != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_reuse_cnt <= '0;
        end else if (w_req_accept) begin
            r_reuse_cnt <= '0;
        end else if (w_inc && !w_dec) begin
            if (r_reuse_cnt != {REUSE_W{1'b1}})
                r_reuse_cnt <= r_reuse_cnt + 1'b1;
        end else if (w_dec && !w_inc) begin
            r_reuse_cnt <= r_reuse_cnt - 1'b1;
        end
    end

    assign w_reuse_cnt = r_reuse_cnt;
    wire w_unused = ^{tag_done, next_sync_compute_tag};
`else
    // Without the counter every compute pass is treated as the last one.
    assign w_reuse_cnt = '0;
    wire w_unused = ^{tag_done, next_sync_compute_tag, tag_reuse};
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= S_FREE;
            r_flush        <= 1'b0;
            r_bias_prev_sw <= 1'b0;
            r_ddr_pe_sw    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_req_accept) begin
                r_flush        <= 1'b0;
                r_bias_prev_sw <= tag_bias_prev_sw;
                r_ddr_pe_sw    <= tag_ddr_pe_sw;
            end else if (w_exit) begin
                r_flush <= 1'b0;
            end else if (w_active && tag_flush) begin
                r_flush <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FREE:    if (tag_req)        w_state_nxt = S_LDMEM;
            S_LDMEM:   if (ldmem_tag_done) w_state_nxt = S_COMPUTE;
            S_COMPUTE: if (w_exit)         w_state_nxt = STORE_ENABLED ? S_STMEM : S_FREE;
            S_STMEM:   if (stmem_tag_done) w_state_nxt = S_FREE;
            default:                       w_state_nxt = S_FREE;
        endcase
    end

    assign tag_ready            = (r_state == S_FREE);
    assign ldmem_tag_ready      = (r_state == S_LDMEM);
    assign compute_tag_ready    = (r_state == S_COMPUTE);
    assign stmem_tag_ready      = (r_state == S_STMEM);
    assign next_compute_tag     = w_exit;
    assign compute_bias_prev_sw = r_bias_prev_sw;
    assign stmem_ddr_pe_sw      = r_ddr_pe_sw;

endmodule

// File: tb/tb_tag_logic_fsm.sv
// Directed bench for tag_logic_fsm; one instance with store phase, one without,
// both driven from the same stimulus.
module tb_tag_logic_fsm;

    localparam logic [3:0] FREE = 4'b1000;
    localparam logic [3:0] LD   = 4'b0100;
    localparam logic [3:0] CO   = 4'b0010;
    localparam logic [3:0] ST   = 4'b0001;

    logic clk = 1'b0;
    logic reset, tag_req, tag_reuse, tag_bias_prev_sw, tag_ddr_pe_sw, tag_flush;
    logic tag_done, next_sync_compute_tag, ldmem_tag_done, compute_tag_done, stmem_tag_done;

    logic tr, lr, cr, sr, nct, bias, ddr;
    logic tr_n, lr_n, cr_n, sr_n, nct_n, bias_n, ddr_n;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    tag_logic_fsm #(.STORE_ENABLED(1'b1), .REUSE_W(4)) u_dut (
        .clk(clk), .reset(reset), .tag_req(tag_req), .tag_reuse(tag_reuse),
        .tag_bias_prev_sw(tag_bias_prev_sw), .tag_ddr_pe_sw(tag_ddr_pe_sw),
        .tag_flush(tag_flush), .tag_done(tag_done),
        .next_sync_compute_tag(next_sync_compute_tag),
        .ldmem_tag_done(ldmem_tag_done), .compute_tag_done(compute_tag_done),
        .stmem_tag_done(stmem_tag_done),
        .tag_ready(tr), .ldmem_tag_ready(lr), .compute_tag_ready(cr),
        .stmem_tag_ready(sr), .next_compute_tag(nct),
        .compute_bias_prev_sw(bias), .stmem_ddr_pe_sw(ddr)
    );

    tag_logic_fsm #(.STORE_ENABLED(1'b0), .REUSE_W(4)) u_dut_ns (
        .clk(clk), .reset(reset), .tag_req(tag_req), .tag_reuse(tag_reuse),
        .tag_bias_prev_sw(tag_bias_prev_sw), .tag_ddr_pe_sw(tag_ddr_pe_sw),
        .tag_flush(tag_flush), .tag_done(tag_done),
        .next_sync_compute_tag(next_sync_compute_tag),
        .ldmem_tag_done(ldmem_tag_done), .compute_tag_done(compute_tag_done),
        .stmem_tag_done(stmem_tag_done),
        .tag_ready(tr_n), .ldmem_tag_ready(lr_n), .compute_tag_ready(cr_n),
        .stmem_tag_ready(sr_n), .next_compute_tag(nct_n),
        .compute_bias_prev_sw(bias_n), .stmem_ddr_pe_sw(ddr_n)
    );

    task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic clr();
        tag_req = 0; tag_reuse = 0; tag_bias_prev_sw = 0; tag_ddr_pe_sw = 0;
        tag_flush = 0; tag_done = 0; next_sync_compute_tag = 0;
        ldmem_tag_done = 0; compute_tag_done = 0; stmem_tag_done = 0;
    endtask

    // Advance one edge, then release all pulse inputs.
    task automatic cyc();
        @(posedge clk);
        #1;
        clr();
        #1;
    endtask

    function automatic logic [3:0] rdy();
        return {tr, lr, cr, sr};
    endfunction

    function automatic logic [3:0] rdy_ns();
        return {tr_n, lr_n, cr_n, sr_n};
    endfunction

    initial begin
        clr();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", rdy(), FREE);
        chk("rst_sw", {2'b00, bias, ddr}, 4'b0000);
        chk("rst_nct", {3'b000, nct}, 4'b0000);
        reset = 1;
        cyc();
        chk("idle_rdy", rdy(), FREE);

        // Basic full lifecycle
        tag_req = 1; tag_bias_prev_sw = 1; tag_ddr_pe_sw = 0;
        cyc();
        chk("f1_ld", rdy(), LD);
        chk("f1_sw", {2'b00, bias, ddr}, 4'b0010);
        chk("f1_ns_ld", rdy_ns(), LD);
        chk("f1_nct_ld", {3'b000, nct}, 4'b0000);
        ldmem_tag_done = 1;
        cyc();
        chk("f1_co", rdy(), CO);
        chk("f1_nct_co", {3'b000, nct}, 4'b0000);
        compute_tag_done = 1; tag_flush = 1;
        #1;
        chk("f1_nct_pulse", {2'b00, nct, nct_n}, 4'b0011);
        cyc();
        chk("f1_st", rdy(), ST);
        chk("f1_ns_free", rdy_ns(), FREE);
        chk("f1_nct_st", {3'b000, nct}, 4'b0000);
        chk("f1_sw_st", {2'b00, bias, ddr}, 4'b0010);
        stmem_tag_done = 1;
        cyc();
        chk("f1_free", rdy(), FREE);
        chk("f1_sw_hold", {2'b00, bias, ddr}, 4'b0010);

        // Reuse counting
        tag_req = 1; tag_bias_prev_sw = 0; tag_ddr_pe_sw = 1;
        cyc();
        chk("f2_sw", {2'b00, bias, ddr}, 4'b0001);
        ldmem_tag_done = 1;
        cyc();
        chk("f2_co", rdy(), CO);
        tag_reuse = 1; cyc();
        tag_reuse = 1; cyc();
        tag_flush = 1; cyc();
        chk("f2_co_flush", rdy(), CO);
        compute_tag_done = 1;
        #1;
`ifdef TAG_LOGIC_REUSE_EN
        chk("f2_nct_d1", {3'b000, nct}, 4'b0000);
        cyc();
        chk("f2_co_d1", rdy(), CO);
        compute_tag_done = 1;
        #1;
        chk("f2_nct_d2", {3'b000, nct}, 4'b0000);
        cyc();
        chk("f2_co_d2", rdy(), CO);
        compute_tag_done = 1;
        #1;
        chk("f2_nct_d3", {3'b000, nct}, 4'b0001);
        cyc();
        chk("f2_st", rdy(), ST);
        chk("f2_ns_free", rdy_ns(), FREE);
`else
        chk("f2_nct_d1", {3'b000, nct}, 4'b0001);
        cyc();
        chk("f2_st", rdy(), ST);
        chk("f2_ns_free", rdy_ns(), FREE);
`endif
        stmem_tag_done = 1;
        cyc();
        chk("f2_free", rdy(), FREE);
        chk("f2_ns_stay", rdy_ns(), FREE);

        // compute_tag_done without flush pending
        tag_req = 1; cyc();
        ldmem_tag_done = 1; cyc();
        compute_tag_done = 1;
        #1;
        chk("f3_nct_noflush", {2'b00, nct, nct_n}, 4'b0000);
        cyc();
        chk("f3_co", rdy(), CO);
        chk("f3_ns_co", rdy_ns(), CO);
        tag_flush = 1; cyc();
        compute_tag_done = 1;
        #1;
        chk("f3_nct", {2'b00, nct, nct_n}, 4'b0011);
        cyc();
        chk("f3_st", rdy(), ST);
        chk("f3_ns_free", rdy_ns(), FREE);
        stmem_tag_done = 1; cyc();
        chk("f3_free", rdy(), FREE);

        // Ignored inputs, then reset mid-operation
        ldmem_tag_done = 1; compute_tag_done = 1; stmem_tag_done = 1;
        cyc();
        chk("f4_free_ign", rdy(), FREE);
        tag_req = 1; tag_bias_prev_sw = 1; tag_ddr_pe_sw = 1;
        cyc();
        chk("f4_ld", rdy(), LD);
        tag_req = 1; tag_bias_prev_sw = 0; tag_ddr_pe_sw = 0; stmem_tag_done = 1;
        cyc();
        chk("f4_ld_ign", rdy(), LD);
        chk("f4_sw_hold", {2'b00, bias, ddr}, 4'b0011);
        ldmem_tag_done = 1; cyc();
        chk("f4_co", rdy(), CO);
        tag_reuse = 1; cyc();
        tag_reuse = 1; cyc();
        reset = 0;
        cyc();
        chk("f4_rst_rdy", rdy(), FREE);
        chk("f4_rst_sw", {2'b00, bias, ddr}, 4'b0000);
        chk("f4_rst_ns", rdy_ns(), FREE);
        reset = 1;
        tag_req = 1; cyc();
        ldmem_tag_done = 1; cyc();
        compute_tag_done = 1; tag_flush = 1;
        #1;
        chk("f4_cnt_clr", {3'b000, nct}, 4'b0001);
        cyc();
        chk("f4_st", rdy(), ST);
        stmem_tag_done = 1; cyc();
        chk("f4_free", rdy(), FREE);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
